dram_resp_model: RTL and testbench

//  Synthesizable DRAM responder for the Top accelerator's DRAM cmd/resp port; sits opposite io_dram_cmd_*/io_dram_resp_*.
//  - Accepts burst read/write commands and stores 64-byte bursts in an internal array.
//  - Returns exactly one response per command, in order, after a fixed latency.
//  - Replaces the software DRAM model for standalone and FPGA runs.

---
 rtl/dram_resp_model.sv | 108 ++++++++++
 tb/tb_dram_resp_model.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_resp_model.sv
// dram_resp_model: synthesizable DRAM responder for the accelerator DRAM cmd/resp port
// Stores 64-byte bursts in an internal array and returns one response per command, in order, after LATENCY cycles.
// Ports:
//   clock, reset (async, active-high)
//   io_dram_cmd_valid/ready, io_dram_cmd_bits_{addr,isWr,tag,streamId,wdata}  command channel
//   io_dram_resp_valid/ready, io_dram_resp_bits_{rdata,tag,streamId}          response channel
//   io_stat_reads/writes/stalls  saturating counters, present only with DRAM_MODEL_STATS_EN defined
module dram_resp_model #(
   parameter int WORDS      = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 8,
   parameter int QDEPTH     = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_dram_cmd_valid,
   output logic                  io_dram_cmd_ready,
   input  logic [31:0]           io_dram_cmd_bits_addr,
   input  logic                  io_dram_cmd_bits_isWr,
   input  logic [31:0]           io_dram_cmd_bits_tag,
   input  logic [31:0]           io_dram_cmd_bits_streamId,
   input  logic [WORDS*32-1:0]   io_dram_cmd_bits_wdata,
   output logic                  io_dram_resp_valid,
   input  logic                  io_dram_resp_ready,
   output logic [WORDS*32-1:0]   io_dram_resp_bits_rdata,
   output logic [31:0]           io_dram_resp_bits_tag,
   output logic [31:0]           io_dram_resp_bits_streamId
`ifdef DRAM_MODEL_STATS_EN
   ,
   output logic [31:0]           io_stat_reads,
   output logic [31:0]           io_stat_writes,
   output logic [31:0]           io_stat_stalls
`endif
);
   localparam int DW = WORDS * 32;
   localparam int EW = DW + 64;
   localparam int AW = $clog2(QDEPTH);
   localparam int ND = 1 << DEPTH_LOG2;
   localparam logic [AW:0] QD = (AW + 1)'(QDEPTH);

   logic [DW-1:0]         mem [ND];
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           unused_addr;
   logic [DW-1:0]         entry_rdata;
   logic                  accept, pop, push, empty;
   logic [LATENCY-1:0]    dl_v;
   logic [EW-1:0]         dl_d [LATENCY];
   logic [EW-1:0]         fifo [QDEPTH];
   logic [EW-1:0]         head;
   logic [AW:0]           wr_ptr, rd_ptr, out_cnt;

   assign idx         = io_dram_cmd_bits_addr[6+DEPTH_LOG2-1:6];
   assign unused_addr = io_dram_cmd_bits_addr;
   assign io_dram_cmd_ready = ~reset & (out_cnt != QD);
   assign accept      = io_dram_cmd_valid & io_dram_cmd_ready;
   assign pop         = io_dram_resp_valid & io_dram_resp_ready;
   assign push        = dl_v[LATENCY-1];
   assign empty       = wr_ptr == rd_ptr;
   // read data is taken before this edge's write, so a write from an earlier cycle is visible
   assign entry_rdata = io_dram_cmd_bits_isWr ? '0 : mem[idx];
   assign head        = empty ? '0 : fifo[rd_ptr[AW-1:0]];
   assign io_dram_resp_valid = ~empty;
   assign {io_dram_resp_bits_rdata, io_dram_resp_bits_tag, io_dram_resp_bits_streamId} = head;

   // memory contents survive reset
   always_ff @(posedge clock)
      if (accept & io_dram_cmd_bits_isWr) mem[idx] <= io_dram_cmd_bits_wdata;

   always_ff @(posedge clock or posedge reset)
      if (reset) dl_v <= '0;
      else begin
         dl_v[0] <= accept;
         for (int i = 1; i < LATENCY; i++) dl_v[i] <= dl_v[i-1];
      end

   always_ff @(posedge clock) begin
      dl_d[0] <= {entry_rdata, io_dram_cmd_bits_tag, io_dram_cmd_bits_streamId};
      for (int i = 1; i < LATENCY; i++) dl_d[i] <= dl_d[i-1];
   end

   // out_cnt credits cover both the delay line and the FIFO, so push never overflows
   always_ff @(posedge clock)
      if (push) fifo[wr_ptr[AW-1:0]] <= dl_d[LATENCY-1];

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         out_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (accept != pop) out_cnt <= accept ? out_cnt + 1'b1 : out_cnt - 1'b1;
      end

`ifdef DRAM_MODEL_STATS_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         io_stat_reads  <= '0;
         io_stat_writes <= '0;
         io_stat_stalls <= '0;
      end else begin
         if (accept & ~io_dram_cmd_bits_isWr & ~&io_stat_reads) io_stat_reads <= io_stat_reads + 1'b1;
         if (accept & io_dram_cmd_bits_isWr & ~&io_stat_writes) io_stat_writes <= io_stat_writes + 1'b1;
         if (io_dram_cmd_valid & ~io_dram_cmd_ready & ~&io_stat_stalls) io_stat_stalls <= io_stat_stalls + 1'b1;
      end
`endif
endmodule

// File: tb/tb_dram_resp_model.sv
// tb_dram_resp_model: directed bench with a queue-based reference model for dram_resp_model
module tb_dram_resp_model;
   localparam int WORDS = 16;
   localparam int DL    = 10;
   localparam int LAT   = 8;
   localparam int QD    = 8;
   localparam int DW    = WORDS * 32;

   logic          clock = 0;
   logic          reset = 1;
   logic          cmd_valid = 0, cmd_ready, cmd_isWr = 0;
   logic [31:0]   cmd_addr = 0, cmd_tag = 0, cmd_sid = 0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          resp_valid, resp_ready = 1;
   logic [DW-1:0] resp_rdata;
   logic [31:0]   resp_tag, resp_sid;
`ifdef DRAM_MODEL_STATS_EN
   logic [31:0]   st_r, st_w, st_s;
`endif

   always #5 clock = ~clock;

   dram_resp_model #(.WORDS(WORDS), .DEPTH_LOG2(DL), .LATENCY(LAT), .QDEPTH(QD)) dut (
      .clock(clock), .reset(reset),
      .io_dram_cmd_valid(cmd_valid), .io_dram_cmd_ready(cmd_ready),
      .io_dram_cmd_bits_addr(cmd_addr), .io_dram_cmd_bits_isWr(cmd_isWr),
      .io_dram_cmd_bits_tag(cmd_tag), .io_dram_cmd_bits_streamId(cmd_sid),
      .io_dram_cmd_bits_wdata(cmd_wdata),
      .io_dram_resp_valid(resp_valid), .io_dram_resp_ready(resp_ready),
      .io_dram_resp_bits_rdata(resp_rdata), .io_dram_resp_bits_tag(resp_tag),
      .io_dram_resp_bits_streamId(resp_sid)
`ifdef DRAM_MODEL_STATS_EN
      , .io_stat_reads(st_r), .io_stat_writes(st_w), .io_stat_stalls(st_s)
`endif
   );

   int total = 0, bad = 0, cyc = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // reference model: outstanding responses with the cycle they become visible
   typedef struct {
      logic [DW-1:0] d;
      logic [31:0]   t;
      logic [31:0]   s;
      int            due;
      bit            known;
   } ent_t;
   ent_t          q[$];
   logic [DW-1:0] mm [int];
   int            m_reads = 0, m_writes = 0, m_stalls = 0;
   logic [31:0]   dut_pops[$];

   always @(posedge reset) begin
      q.delete();
      m_reads = 0; m_writes = 0; m_stalls = 0;
   end

   always @(posedge clock) begin
      ent_t e;
      bit mv, mr;
      int ix;
      if (reset) begin
         q.delete();
         m_reads = 0; m_writes = 0; m_stalls = 0;
      end else begin
         mv = q.size() > 0 && q[0].due <= cyc;
         mr = q.size() < QD;
         ix = int'(cmd_addr[6+DL-1:6]);
         if (cmd_valid && !mr) m_stalls++;
         if (mv && resp_ready) void'(q.pop_front());
         if (cmd_valid && mr) begin
            e.t = cmd_tag;
            e.s = cmd_sid;
            e.due = cyc + 1 + LAT;
            if (cmd_isWr) begin
               e.d = '0; e.known = 1;
               mm[ix] = cmd_wdata;
               m_writes++;
            end else begin
               e.known = mm.exists(ix);
               e.d = e.known ? mm[ix] : '0;
               m_reads++;
            end
            q.push_back(e);
         end
      end
      cyc++;
   end

   always @(negedge clock) begin
      bit ev, er;
      er = !reset && q.size() < QD;
      ev = !reset && q.size() > 0 && q[0].due <= cyc;
      chk("cmd_ready", DW'(cmd_ready), DW'(er));
      chk("resp_valid", DW'(resp_valid), DW'(ev));
      if (reset) begin
         chk("rst_rdata", resp_rdata, '0);
         chk("rst_tag", DW'(resp_tag), '0);
         chk("rst_sid", DW'(resp_sid), '0);
      end
      if (ev) begin
         chk("resp_tag", DW'(resp_tag), DW'(q[0].t));
         chk("resp_sid", DW'(resp_sid), DW'(q[0].s));
         if (q[0].known) chk("resp_rdata", resp_rdata, q[0].d);
      end
      if (resp_valid && resp_ready) dut_pops.push_back(resp_tag);
`ifdef DRAM_MODEL_STATS_EN
      chk("stat_reads", DW'(st_r), DW'(m_reads));
      chk("stat_writes", DW'(st_w), DW'(m_writes));
      chk("stat_stalls", DW'(st_s), DW'(m_stalls));
`endif
   end

   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] t, input logic [DW-1:0] d);
      bit ok = 0;
      cmd_addr = a; cmd_isWr = w; cmd_tag = t; cmd_sid = t + 32'h1000; cmd_wdata = d; cmd_valid = 1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clock);
         ok = cmd_ready;
         @(posedge clock);
         #1;
      end
      cmd_valid = 0;
      if (!ok) chk("issue_accept", DW'(ok), DW'(1));
   endtask

   task automatic wait_tag(input logic [31:0] t, output logic [DW-1:0] d, output bit ok);
      ok = 0; d = '0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clock);
         if (resp_valid && resp_tag == t) begin
            ok = 1; d = resp_rdata;
         end
      end
   endtask

   task automatic drain;
      for (int k = 0; k < 300 && q.size() > 0; k++) @(posedge clock);
      @(posedge clock);
      #1;
      chk("drained", DW'(resp_valid), '0);
   endtask

   logic [DW-1:0] wd, rd;
   bit            ok, r;
   int            e, n, nv;

   initial begin
      for (int i = 0; i < WORDS; i++) wd[32*i +: 32] = 32'(i + 'h100);
      repeat (3) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("idle_ready", DW'(cmd_ready), DW'(1));
      chk("idle_valid", DW'(resp_valid), '0);
      @(posedge clock);
      #1;

      // write then read of the same burst
      issue(32'h40, 1'b1, 32'd5, wd);
      e = cyc;
      issue(32'h40, 1'b0, 32'd6, '0);
      while (cyc < e + LAT - 1) @(negedge clock);
      chk("wr_early_valid", DW'(resp_valid), '0);
      @(negedge clock);
      chk("wr_valid", DW'(resp_valid), DW'(1));
      chk("wr_tag", DW'(resp_tag), DW'(5));
      chk("wr_rdata", resp_rdata, '0);
      @(negedge clock);
      chk("rd_tag", DW'(resp_tag), DW'(6));
      chk("rd_rdata", resp_rdata, wd);
      drain();

      // aliasing: 0x10000 maps onto burst 0
      issue(32'h0, 1'b1, 32'd20, {WORDS{32'h5555_5555}});
      issue(32'h10000, 1'b1, 32'd21, {WORDS{32'hAAAA_AAAA}});
      issue(32'h0, 1'b0, 32'd22, '0);
      wait_tag(32'd22, rd, ok);
      chk("alias_seen", DW'(ok), DW'(1));
      chk("alias_data", rd, {WORDS{32'hAAAA_AAAA}});
      drain();

      // backpressure: nine reads against eight credits
      dut_pops.delete();
      resp_ready = 0; n = 0;
      cmd_addr = 32'h40; cmd_isWr = 0; cmd_tag = 10; cmd_sid = 32'h1000 + 10; cmd_valid = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         r = cmd_ready;
         @(posedge clock);
         #1;
         if (r) begin
            n++;
            cmd_tag = 32'(10 + n);
            cmd_sid = 32'(32'h1000 + 10 + n);
         end
      end
      chk("bp_accepted", DW'(n), DW'(8));
      @(negedge clock);
      chk("bp_ready_low", DW'(cmd_ready), '0);
      @(posedge clock);
      #1 resp_ready = 1;
      @(negedge clock);
      chk("bp_ready_prepop", DW'(cmd_ready), '0);
      @(negedge clock);
      chk("bp_ready_back", DW'(cmd_ready), DW'(1));
      @(posedge clock);
      #1 cmd_valid = 0;
      drain();
      chk("bp_pop_count", DW'(dut_pops.size()), DW'(9));
      for (int i = 0; i < 9 && i < dut_pops.size(); i++) chk("bp_pop_order", DW'(dut_pops[i]), DW'(10 + i));

      // reset while four reads are in flight
      for (int i = 0; i < 4; i++) issue(32'h40, 1'b0, 32'(40 + i), '0);
      repeat (2) @(posedge clock);
      @(posedge clock);
      #1 reset = 1;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 0;
      nv = 0;
      repeat (20) begin
         @(negedge clock);
         if (resp_valid) nv++;
      end
      chk("mrst_no_resp", DW'(nv), '0);
      @(posedge clock);
      #1;
      issue(32'h40, 1'b0, 32'd44, '0);
      wait_tag(32'd44, rd, ok);
      chk("mrst_seen", DW'(ok), DW'(1));
      chk("mrst_data", rd, wd);
      drain();

`ifdef DRAM_MODEL_STATS_EN
      reset = 1;
      @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("st_zero", DW'({st_r, st_w, st_s}), '0);
      @(posedge clock);
      #1 resp_ready = 0;
      for (int i = 0; i < 6; i++) issue(32'h40, 1'b0, 32'(30 + i), '0);
      issue(32'h80, 1'b1, 32'd36, wd);
      issue(32'hC0, 1'b1, 32'd37, wd);
      cmd_addr = 32'h40; cmd_isWr = 0; cmd_tag = 38; cmd_valid = 1;
      repeat (4) @(posedge clock);
      #1 cmd_valid = 0;
      @(negedge clock);
      chk("st_reads", DW'(st_r), DW'(6));
      chk("st_writes", DW'(st_w), DW'(2));
      chk("st_stalls", DW'(st_s), DW'(4));
      @(posedge clock);
      #1 resp_ready = 1;
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
